// File: rtl/twomux_arb_if.sv
// Handshake bundle for twomux_arb: two valid/ready input channels and the registered 2:1 mux drive triple.
interface twomux_arb_if #(
    parameter int DW = 4
);
    logic          a_valid;
    logic [DW-1:0] a_data;
    logic          a_ready;
    logic          b_valid;
    logic [DW-1:0] b_data;
    logic          b_ready;
    logic [DW-1:0] dina;
    logic [DW-1:0] dinb;
    logic          sel;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output a_valid, a_data, b_valid, b_data, out_ready,
        input  a_ready, b_ready, dina, dinb, sel, out_valid
    );

    modport slave (
        input  a_valid, a_data, b_valid, b_data, out_ready,
        output a_ready, b_ready, dina, dinb, sel, out_valid
    );
endinterface

// File: rtl/twomux_arb.sv
// Purpose: round-robin arbiter feeding a registered 2:1 mux triple (dina/dinb/sel) from two 2-deep FIFOs.
// Latency: word accepted at edge k is presented after edge k+1 at the earliest; one grant per cycle.
// Backpressure: a_ready/b_ready depend only on FIFO occupancy; out_ready=0 freezes the triple and stops pops.
module twomux_arb #(
    parameter int DW = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    twomux_arb_if.slave bus
);
    logic [DW-1:0] a_mem [2];
    logic [DW-1:0] b_mem [2];
    logic          a_wp, a_rp, b_wp, b_rp;
    logic [1:0]    a_cnt, b_cnt;
    logic [DW-1:0] dina_q, dinb_q;
    logic          sel_q, out_valid_q;
    logic          last_grant;  // 1 = A granted last, 0 = B

    logic a_push, b_push, a_ne, b_ne, free, grant_a, grant_b;

    assign bus.a_ready   = (a_cnt != 2'd2);
    assign bus.b_ready   = (b_cnt != 2'd2);
    assign bus.dina      = dina_q;
    assign bus.dinb      = dinb_q;
    assign bus.sel       = sel_q;
    assign bus.out_valid = out_valid_q;

    assign a_push  = bus.a_valid && bus.a_ready;
    assign b_push  = bus.b_valid && bus.b_ready;
    assign a_ne    = (a_cnt != 2'd0);
    assign b_ne    = (b_cnt != 2'd0);
    assign free    = !out_valid_q || bus.out_ready;
    // On a tie the channel that did not win last time gets the slot.
    assign grant_a = free && a_ne && (!b_ne || !last_grant);
    assign grant_b = free && b_ne && (!a_ne ||  last_grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_mem[0]    <= '0;
            a_mem[1]    <= '0;
            b_mem[0]    <= '0;
            b_mem[1]    <= '0;
            a_wp        <= 1'b0;
            a_rp        <= 1'b0;
            b_wp        <= 1'b0;
            b_rp        <= 1'b0;
            a_cnt       <= 2'd0;
            b_cnt       <= 2'd0;
            dina_q      <= '0;
            dinb_q      <= '0;
            sel_q       <= 1'b0;
            out_valid_q <= 1'b0;
            last_grant  <= 1'b0;
        end else begin
            if (a_push) begin
                a_mem[a_wp] <= bus.a_data;
                a_wp        <= ~a_wp;
            end
            if (b_push) begin
                b_mem[b_wp] <= bus.b_data;
                b_wp        <= ~b_wp;
            end
            if (grant_a) a_rp <= ~a_rp;
            if (grant_b) b_rp <= ~b_rp;
            a_cnt <= a_cnt + {1'b0, a_push} - {1'b0, grant_a};
            b_cnt <= b_cnt + {1'b0, b_push} - {1'b0, grant_b};

            if (free) begin
                if (grant_a) begin
                    dina_q      <= a_mem[a_rp];
                    sel_q       <= 1'b1;
                    out_valid_q <= 1'b1;
                    last_grant  <= 1'b1;
                end else if (grant_b) begin
                    dinb_q      <= b_mem[b_rp];
                    sel_q       <= 1'b0;
                    out_valid_q <= 1'b1;
                    last_grant  <= 1'b0;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_twomux_arb.sv
// Self-checking bench for twomux_arb: queue-based reference model plus directed literal scenarios and random traffic.
module tb_twomux_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    twomux_arb_if #(.DW(4)) bus ();
    twomux_arb #(.DW(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: per-channel queues and the visible output triple.
    logic [3:0] qa[$];
    logic [3:0] qb[$];
    logic [3:0] m_dina, m_dinb;
    logic       m_sel, m_ov, m_last_a;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        else
            n_pass++;
    endtask

    task automatic check_all();
        chk("out_valid", {7'd0, bus.out_valid}, {7'd0, m_ov});
        chk("sel",       {7'd0, bus.sel},       {7'd0, m_sel});
        chk("dina",      {4'd0, bus.dina},      {4'd0, m_dina});
        chk("dinb",      {4'd0, bus.dinb},      {4'd0, m_dinb});
        chk("a_ready",   {7'd0, bus.a_ready},   {7'd0, (qa.size() < 2)});
        chk("b_ready",   {7'd0, bus.b_ready},   {7'd0, (qb.size() < 2)});
    endtask

    task automatic model_clear();
        qa.delete();
        qb.delete();
        m_dina = 4'h0; m_dinb = 4'h0; m_sel = 1'b0; m_ov = 1'b0; m_last_a = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.a_valid = 1'b0; bus.a_data = 4'h0;
        bus.b_valid = 1'b0; bus.b_data = 4'h0;
        bus.out_ready = 1'b0;
    endtask

    // Assert reset between edges, verify the asynchronous clear, release after the next edge.
    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("rst_out_valid", {7'd0, bus.out_valid}, 8'd0);
        chk("rst_sel",       {7'd0, bus.sel},       8'd0);
        chk("rst_dina",      {4'd0, bus.dina},      8'd0);
        chk("rst_dinb",      {4'd0, bus.dinb},      8'd0);
        chk("rst_a_ready",   {7'd0, bus.a_ready},   8'd1);
        chk("rst_b_ready",   {7'd0, bus.b_ready},   8'd1);
        model_clear();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Advance one clock: predict from current inputs, then compare #1 after the edge.
    task automatic cycle();
        logic fr, ga, gb, pa, pb;
        logic [3:0] da, db;
        fr = !m_ov || bus.out_ready;
        pa = bus.a_valid && (qa.size() < 2);
        pb = bus.b_valid && (qb.size() < 2);
        da = bus.a_data;
        db = bus.b_data;
        ga = 1'b0;
        gb = 1'b0;
        if (fr) begin
            if (qa.size() > 0 && qb.size() > 0) begin
                if (m_last_a) gb = 1'b1; else ga = 1'b1;
            end else if (qa.size() > 0) ga = 1'b1;
            else if (qb.size() > 0) gb = 1'b1;
        end
        @(posedge clk);
        #1;
        if (fr) begin
            if (ga) begin
                m_dina = qa.pop_front(); m_sel = 1'b1; m_ov = 1'b1; m_last_a = 1'b1;
            end else if (gb) begin
                m_dinb = qb.pop_front(); m_sel = 1'b0; m_ov = 1'b1; m_last_a = 1'b0;
            end else begin
                m_ov = 1'b0;
            end
        end
        if (pa) qa.push_back(da);
        if (pb) qb.push_back(db);
        check_all();
    endtask

    initial begin
        model_clear();
        idle_inputs();
        @(posedge clk);
        #1;
        do_reset();

        // Single A word
        bus.a_valid = 1'b1; bus.a_data = 4'h5; bus.out_ready = 1'b1;
        cycle();
        chk("single_latency_ov", {7'd0, bus.out_valid}, 8'd0);
        bus.a_valid = 1'b0;
        cycle();
        chk("single_ov",   {7'd0, bus.out_valid}, 8'd1);
        chk("single_sel",  {7'd0, bus.sel},       8'd1);
        chk("single_dina", {4'd0, bus.dina},      8'h05);
        chk("single_dinb", {4'd0, bus.dinb},      8'h00);
        cycle();
        chk("single_done_ov", {7'd0, bus.out_valid}, 8'd0);

        // Tie: round-robin A1, B9, A2, BA back-to-back
        do_reset();
        bus.out_ready = 1'b1;
        bus.a_valid = 1'b1; bus.a_data = 4'h1; bus.b_valid = 1'b1; bus.b_data = 4'h9;
        cycle();
        bus.a_data = 4'h2; bus.b_data = 4'hA;
        cycle();
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        chk("tie1", {bus.out_valid, bus.sel, 2'b0, bus.dina}, {2'b11, 2'b0, 4'h1});
        cycle();
        chk("tie2", {bus.out_valid, bus.sel, 2'b0, bus.dinb}, {2'b10, 2'b0, 4'h9});
        cycle();
        chk("tie3", {bus.out_valid, bus.sel, 2'b0, bus.dina}, {2'b11, 2'b0, 4'h2});
        cycle();
        chk("tie4", {bus.out_valid, bus.sel, 2'b0, bus.dinb}, {2'b10, 2'b0, 4'hA});

        // Backpressure: 3 words fill FIFO + output stage, triple frozen, then drain in order
        do_reset();
        bus.out_ready = 1'b0;
        bus.a_valid = 1'b1; bus.a_data = 4'h3; cycle();
        bus.a_data = 4'h4; cycle();
        bus.a_data = 4'h6; cycle();
        chk("bp_a_ready", {7'd0, bus.a_ready}, 8'd0);
        bus.a_data = 4'h7; cycle();
        chk("bp_frozen", {bus.out_valid, bus.sel, 2'b0, bus.dina}, {2'b11, 2'b0, 4'h3});
        bus.a_valid = 1'b0; bus.out_ready = 1'b1;
        cycle();
        chk("bp_drain1", {4'd0, bus.dina}, 8'h04);
        cycle();
        chk("bp_drain2", {4'd0, bus.dina}, 8'h06);
        cycle();
        chk("bp_empty", {7'd0, bus.out_valid}, 8'd0);

        // Simultaneous push/pop on B: ready stays high, values stream in order
        do_reset();
        bus.out_ready = 1'b1;
        bus.b_valid = 1'b1; bus.b_data = 4'h1;
        cycle();
        for (int k = 2; k <= 6; k++) begin
            bus.b_data = 4'(k);
            cycle();
            chk("pp_b_ready", {7'd0, bus.b_ready}, 8'd1);
            chk("pp_sel",     {7'd0, bus.sel},     8'd0);
            chk("pp_dinb",    {4'd0, bus.dinb},    8'(k - 1));
        end
        bus.b_valid = 1'b0;

        // Reset mid-stream with both FIFOs full and a grant pending
        do_reset();
        bus.out_ready = 1'b0;
        bus.a_valid = 1'b1; bus.b_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.a_data = 4'hC + 4'(k); bus.b_data = 4'hD;
            cycle();
        end
        chk("mid_full_a", {6'd0, bus.a_ready, bus.b_ready}, 8'd0);
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.a_valid = (k < 2); bus.a_data = 4'h1;
            bus.b_valid = (k < 2); bus.b_data = 4'h2;
            cycle();
        end

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bus.a_valid   = ($urandom_range(0, 99) < 60);
            bus.a_data    = 4'($urandom);
            bus.b_valid   = ($urandom_range(0, 99) < 60);
            bus.b_data    = 4'($urandom);
            bus.out_ready = ($urandom_range(0, 99) < 70);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/twomux_arb.md
TWOMUX_ARB -- requirements
Module: twomux_arb

Interface
REQ-001 Parameter DW, default 4: data width of both channels and both mux data ports.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 a_valid  input  1  channel A offers a_data this cycle.
REQ-005 a_data  input  DW  channel A payload.
REQ-006 a_ready  output  1  channel A can accept; transfer when a_valid && a_ready at the rising edge.
REQ-007 b_valid  input  1  channel B offers b_data this cycle.
REQ-008 b_data  input  DW  channel B payload.
REQ-009 b_ready  output  1  channel B can accept; transfer when b_valid && b_ready at the rising edge.
REQ-010 dina  output  DW  registered data for the 2:1 mux input selected by sel=1.
REQ-011 dinb  output  DW  registered data for the 2:1 mux input selected by sel=0.
REQ-012 sel  output  1  registered select: 1 = channel A granted, 0 = channel B granted.
REQ-013 out_valid  output  1  the dina/dinb/sel triple holds an unconsumed grant.
REQ-014 out_ready  input  1  downstream consumes the current grant when out_valid && out_ready at the rising edge.

Function
REQ-015 Each channel SHALL have a private 2-entry FIFO (write pointer, read pointer, 2-bit count 0..2).
REQ-016 a_ready SHALL equal (countA < 2); b_ready SHALL equal (countB < 2); combinational from count only, never from out_ready.
REQ-017 Write to a full FIFO SHALL NOT occur; there is no pass-through from input to output in the same cycle.
REQ-018 Output stage "free" SHALL be defined as (!out_valid || out_ready).
REQ-019 When free and both FIFOs non-empty, the channel not equal to last_grant SHALL be granted (round-robin).
REQ-020 When free and exactly one FIFO is non-empty, that channel SHALL be granted regardless of last_grant.
REQ-021 When free and both FIFOs empty, out_valid SHALL go 0 at the edge; dina, dinb, sel, last_grant hold.
REQ-022 On an A grant: dina <= head of FIFO A, sel <= 1, out_valid <= 1, last_grant <= A, FIFO A pops; dinb holds.
REQ-023 On a B grant: dinb <= head of FIFO B, sel <= 0, out_valid <= 1, last_grant <= B, FIFO B pops; dina holds.
REQ-024 When not free (out_valid=1, out_ready=0), dina, dinb, sel, out_valid SHALL hold and no FIFO pops.
REQ-025 Simultaneous push and pop on one FIFO SHALL leave its count unchanged and keep FIFO order.
REQ-026 Pointers SHALL wrap modulo 2; per-channel order SHALL be preserved end to end.
REQ-027 Latency: a word accepted at edge k SHALL appear with out_valid=1 no earlier than after edge k+1.
REQ-028 Throughput: with out_ready held 1 and inputs non-empty, one grant per cycle, no bubbles.
REQ-029 Data SHALL never be dropped or duplicated.

Reset
REQ-030 While rst_n=0, immediately and asynchronously: FIFO counts and pointers = 0, out_valid=0, sel=0, dina=0, dinb=0, last_grant=B.
REQ-031 During and after reset a_ready=1 and b_ready=1 (both FIFOs empty).
REQ-032 Reset asserted mid-transfer SHALL discard all buffered and pending words; first grant after release follows REQ-019/020 with last_grant=B.

Verification
REQ-033 Single A word: after reset push a_data=4'h5 at edge 1, out_ready=1 -> after edge 2 out_valid=1, sel=1, dina=4'h5, dinb=4'h0; after edge 3 out_valid=0.
REQ-034 Tie: A holds 4'h1,4'h2, B holds 4'h9,4'hA, out_ready=1 -> grant order A1, B9, A2, BA with sel 1,0,1,0, back-to-back.
REQ-035 Backpressure: out_ready=0, a_valid held with 4'h3,4'h4,4'h6 -> a_ready drops to 0 after 3 words (2 in FIFO, 1 in output); triple frozen at dina=4'h3, sel=1; on out_ready=1 remaining words drain in order.
REQ-036 Push/pop same cycle: countB=1, out_ready=1, b_valid continuous -> b_ready stays 1, countB stays 1, sel=0 every cycle, values in order.
REQ-037 Reset mid-stream: both FIFOs full, out_valid=1; pulse rst_n low between edges -> out_valid, sel, dina, dinb 0 immediately; a_ready=b_ready=1; no pre-reset word ever appears afterward.
